// File: rtl/dds_param_scheduler_if.sv
// Command and MAC-facing bundle of the DDS parameter scheduler.
// The master side issues commands and returns MAC phase; the slave side is the scheduler.
interface dds_param_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned TW = 48;
  localparam int unsigned PW = 14;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_time;
  logic [TW-1:0] cmd_freq;
  logic [PW-1:0] cmd_phase;
  logic          cmd_continuous;
  logic [TW-1:0] phase_fb;
  logic [TW-1:0] timestamp_out;
  logic [TW-1:0] time_offset;
  logic [TW-1:0] freq;
  logic [PW-1:0] phase;
  logic [TW-1:0] acc_phase;
  logic          update_pulse;
  logic          late_pulse;
  logic [CW-1:0] fifo_count;

  modport master (
    output cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_continuous, phase_fb,
    input  cmd_ready, timestamp_out, time_offset, freq, phase, acc_phase,
           update_pulse, late_pulse, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_continuous, phase_fb,
    output cmd_ready, timestamp_out, time_offset, freq, phase, acc_phase,
           update_pulse, late_pulse, fifo_count
  );
endinterface

// File: rtl/dds_param_scheduler.sv
// DDS phase-MAC parameter scheduler: time-tagged command FIFO, 48-bit timestamp
// counter, and atomic coherent/continuous parameter updates at scheduled times.
module dds_param_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAC_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_param_scheduler_if.slave bus
);
  localparam int unsigned TW = 48;
  localparam int unsigned PW = 14;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAT_C   = TW'(MAC_LATENCY);

  typedef struct packed {
    logic [TW-1:0] tstamp;
    logic [TW-1:0] freq;
    logic [PW-1:0] phase;
    logic          cont;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE
  } state_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  state_t        state_q;
  logic [TW-1:0] ts_q;
  logic [TW-1:0] toff_q;
  logic [TW-1:0] freq_q;
  logic [PW-1:0] phase_q;
  logic [TW-1:0] acc_q;
  logic          upd_q;
  logic          late_q;
  logic [TW-1:0] cap_time_q;
  logic [TW-1:0] cap_freq_q;
  logic [PW-1:0] cap_phase_q;
  logic          cap_late_q;

  cmd_t          in_c;
  cmd_t          head_c;
  logic [TW-1:0] next_ts_c;
  logic          ready_c;
  logic          push_c;
  logic          pop_c;
  logic          hit_c;
  logic          late_c;
  logic          cap_done_c;

  // Handshake, head-of-queue evaluation against the next timestamp, capture timing
  always_comb begin
    in_c.tstamp = bus.cmd_time;
    in_c.freq   = bus.cmd_freq;
    in_c.phase  = bus.cmd_phase;
    in_c.cont   = bus.cmd_continuous;
    ready_c     = !reset && (count_q < DEPTH_C);
    push_c      = bus.cmd_valid && ready_c;
    head_c      = mem_q[rd_ptr_q];
    next_ts_c   = ts_q + TW'(1);
    hit_c       = (state_q == S_ARMED) && (count_q != '0) && (head_c.tstamp <= next_ts_c);
    late_c      = hit_c && (head_c.tstamp != next_ts_c);
    pop_c       = hit_c;
    cap_done_c  = (state_q == S_CAPTURE) && (ts_q == cap_time_q + LAT_C);
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
  end

  // Command storage; contents are only read while the count says they are valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Scheduler FSM; all MAC-facing outputs change together, only on update cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      toff_q      <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      upd_q       <= 1'b0;
      late_q      <= 1'b0;
      cap_time_q  <= '0;
      cap_freq_q  <= '0;
      cap_phase_q <= '0;
      cap_late_q  <= 1'b0;
    end else begin
      ts_q   <= next_ts_c;
      upd_q  <= 1'b0;
      late_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (hit_c) begin
            if (head_c.cont) begin
              cap_time_q  <= next_ts_c;
              cap_freq_q  <= head_c.freq;
              cap_phase_q <= head_c.phase;
              cap_late_q  <= late_c;
              state_q     <= S_CAPTURE;
            end else begin
              toff_q  <= next_ts_c;
              freq_q  <= head_c.freq;
              phase_q <= head_c.phase;
              acc_q   <= '0;
              upd_q   <= 1'b1;
              late_q  <= late_c;
              state_q <= (count_d != '0) ? S_ARMED : S_IDLE;
            end
          end
        end
        S_CAPTURE: begin
          // phase_fb now reflects timestamp T under the old parameters
          if (cap_done_c) begin
            toff_q  <= cap_time_q;
            freq_q  <= cap_freq_q;
            phase_q <= cap_phase_q;
            acc_q   <= bus.phase_fb;
            upd_q   <= 1'b1;
            late_q  <= cap_late_q;
            state_q <= (count_d != '0) ? S_ARMED : S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = ready_c;
  assign bus.timestamp_out = ts_q;
  assign bus.time_offset   = toff_q;
  assign bus.freq          = freq_q;
  assign bus.phase         = phase_q;
  assign bus.acc_phase     = acc_q;
  assign bus.update_pulse  = upd_q;
  assign bus.late_pulse    = late_q;
  assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_dds_param_scheduler.sv
// Bench for dds_param_scheduler: directed vector table, reset-in-capture sequence,
// then randomized commands against an event-level schedule model.
module tb_dds_param_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 3;
  localparam int unsigned NV    = 10;
  localparam int unsigned MAXC  = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dds_param_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();
  dds_param_scheduler #(.FIFO_DEPTH(DEPTH), .MAC_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    longint      offer;
    logic [47:0] t;
    logic [47:0] f;
    logic [13:0] p;
    bit          cont;
  } stim_t;

  typedef struct {
    stim_t       in;
    longint      exp_u;
    logic [47:0] exp_toff;
    logic [47:0] exp_acc;
    bit          exp_late;
  } vec_t;

  // One accepted command with its derived schedule: accept cycle, effective time,
  // pop cycle, and the cycle its update is visible.
  typedef struct {
    longint      a;
    longint      tt;
    longint      s;
    longint      u;
    logic [47:0] f;
    logic [13:0] p;
    bit          cont;
    bit          late;
  } sched_t;

  vec_t        vecs [NV];
  stim_t       stimq [$];
  sched_t      sched [$];
  logic [47:0] fb_hist [MAXC];
  longint      c, last_u, last_t, exp_cnt;
  int          n_checks, n_errors, tbl_idx, n_upd;
  bit          dir_mode, rand_mode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, c);
    end
  endtask

  function automatic vec_t mkv(input longint off, input longint t, input longint f,
                               input int p, input bit cont, input longint eu,
                               input longint etoff, input longint eacc, input bit el);
    vec_t v;
    v.in.offer  = off;
    v.in.t      = 48'(t);
    v.in.f      = 48'(f);
    v.in.p      = 14'(p);
    v.in.cont   = cont;
    v.exp_u     = eu;
    v.exp_toff  = 48'(etoff);
    v.exp_acc   = 48'(eacc);
    v.exp_late  = el;
    return v;
  endfunction

  // Schedule rules: the scheduler starts looking at a command either when the
  // previous update lands (if already queued) or two cycles after acceptance.
  task automatic accept(input stim_t s);
    sched_t e;
    longint arm, t;
    t      = longint'(s.t);
    arm    = (c <= last_u - 1) ? last_u : c + 2;
    e.a    = c;
    e.tt   = (t > arm + 1) ? t : arm + 1;
    e.late = (t < arm + 1);
    e.s    = e.tt - 1;
    e.u    = s.cont ? e.tt + longint'(LAT) + 1 : e.tt;
    e.f    = s.f;
    e.p    = s.p;
    e.cont = s.cont;
    last_u = e.u;
    sched.push_back(e);
  endtask

  task automatic check_model();
    longint      cnt;
    bit          upd, lt;
    logic [47:0] toff, fr, ac;
    logic [13:0] ph;
    cnt = 0; upd = 1'b0; lt = 1'b0; toff = '0; fr = '0; ac = '0; ph = '0;
    foreach (sched[i]) begin
      if (sched[i].a < c) cnt++;
      if (sched[i].s < c) cnt--;
      if (sched[i].u <= c) begin
        toff = 48'(sched[i].tt);
        fr   = sched[i].f;
        ph   = sched[i].p;
        ac   = sched[i].cont ? fb_hist[int'(sched[i].tt + longint'(LAT))] : 48'h0;
      end
      if (sched[i].u == c) begin
        upd = 1'b1;
        lt  = sched[i].late;
      end
    end
    exp_cnt = cnt;
    chk("timestamp_out", 64'(bus.timestamp_out), 64'(c));
    chk("fifo_count", 64'(bus.fifo_count), 64'(cnt));
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(cnt < longint'(DEPTH)));
    chk("update_pulse", 64'(bus.update_pulse), 64'(upd));
    chk("late_pulse", 64'(bus.late_pulse), 64'(lt));
    chk("time_offset", 64'(bus.time_offset), 64'(toff));
    chk("freq", 64'(bus.freq), 64'(fr));
    chk("phase", 64'(bus.phase), 64'(ph));
    chk("acc_phase", 64'(bus.acc_phase), 64'(ac));
    if (bus.update_pulse === 1'b1) begin
      if (rand_mode) n_upd++;
      if (dir_mode) begin
        if (tbl_idx < int'(NV)) begin
          chk("vec_update_ts", 64'(c), 64'(vecs[tbl_idx].exp_u));
          chk("vec_time_offset", 64'(bus.time_offset), 64'(vecs[tbl_idx].exp_toff));
          chk("vec_freq", 64'(bus.freq), 64'(vecs[tbl_idx].in.f));
          chk("vec_phase", 64'(bus.phase), 64'(vecs[tbl_idx].in.p));
          chk("vec_acc_phase", 64'(bus.acc_phase), 64'(vecs[tbl_idx].exp_acc));
          chk("vec_late", 64'(bus.late_pulse), 64'(vecs[tbl_idx].exp_late));
        end
        tbl_idx++;
      end
    end
  endtask

  task automatic hand_checks();
    if (c == 53) begin
      chk("old_freq_at_53", 64'(bus.freq), 64'h1000);
      chk("old_offset_at_53", 64'(bus.time_offset), 64'd20);
    end
    if (c == 160) begin
      chk("full_ready", 64'(bus.cmd_ready), 64'd0);
      chk("full_count", 64'(bus.fifo_count), 64'd4);
    end
    if (c == 200) chk("ready_after_pop", 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic gen_rand();
    stim_t  s;
    longint cand;
    cand = c + longint'($urandom_range(0, 40)) - 8;
    if (cand < last_t) cand = last_t;
    last_t  = cand;
    s.offer = c + longint'($urandom_range(0, 3));
    s.t     = 48'(cand);
    s.f     = {16'($urandom), $urandom};
    s.p     = 14'($urandom);
    s.cont  = 1'($urandom);
    stimq.push_back(s);
  endtask

  task automatic drive();
    logic [47:0] fb;
    if (rand_mode) fb = {16'($urandom), $urandom};
    else           fb = (c == 53) ? 48'hABCDEF : (48'(c) << 8);
    bus.phase_fb = fb;
    fb_hist[int'(c)] = fb;
    if (rand_mode && stimq.size() == 0 && $urandom_range(0, 1) == 0) gen_rand();
    if (stimq.size() > 0 && stimq[0].offer <= c) begin
      bus.cmd_valid      = 1'b1;
      bus.cmd_time       = stimq[0].t;
      bus.cmd_freq       = stimq[0].f;
      bus.cmd_phase      = stimq[0].p;
      bus.cmd_continuous = stimq[0].cont;
      if (exp_cnt < longint'(DEPTH)) accept(stimq.pop_front());
    end else begin
      bus.cmd_valid      = 1'b0;
      bus.cmd_time       = {16'($urandom), $urandom};
      bus.cmd_freq       = {16'($urandom), $urandom};
      bus.cmd_phase      = 14'($urandom);
      bus.cmd_continuous = 1'($urandom);
    end
  endtask

  task automatic step();
    check_model();
    if (dir_mode) hand_checks();
    drive();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic model_reset();
    sched.delete();
    stimq.delete();
    last_u = -1000;
    last_t = 0;
    c      = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_timestamp", 64'(bus.timestamp_out), 64'd0);
    chk("rst_time_offset", 64'(bus.time_offset), 64'd0);
    chk("rst_freq", 64'(bus.freq), 64'd0);
    chk("rst_phase", 64'(bus.phase), 64'd0);
    chk("rst_acc_phase", 64'(bus.acc_phase), 64'd0);
    chk("rst_update", 64'(bus.update_pulse), 64'd0);
    chk("rst_late", 64'(bus.late_pulse), 64'd0);
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; tbl_idx = 0; n_upd = 0;
    dir_mode = 1'b0; rand_mode = 1'b0; exp_cnt = 0;
    bus.cmd_valid = 1'b0; bus.cmd_time = '0; bus.cmd_freq = '0;
    bus.cmd_phase = '0; bus.cmd_continuous = 1'b0; bus.phase_fb = '0;
    reset = 1'b1;
    model_reset();

    vecs[0] = mkv(2,   20,  48'h1000, 14'h155,  1'b0, 20,  20,  0,          1'b0);
    vecs[1] = mkv(30,  50,  48'h2222, 14'h0AA,  1'b1, 54,  50,  48'hABCDEF, 1'b0);
    vecs[2] = mkv(100, 40,  48'h3333, 14'h3FFF, 1'b0, 103, 103, 0,          1'b1);
    vecs[3] = mkv(150, 200, 48'h4000, 14'h10,   1'b0, 200, 200, 0,          1'b0);
    vecs[4] = mkv(150, 210, 48'h4001, 14'h11,   1'b0, 210, 210, 0,          1'b0);
    vecs[5] = mkv(150, 220, 48'h4002, 14'h12,   1'b0, 220, 220, 0,          1'b0);
    vecs[6] = mkv(150, 230, 48'h4003, 14'h13,   1'b0, 230, 230, 0,          1'b0);
    vecs[7] = mkv(154, 240, 48'h4004, 14'h14,   1'b0, 240, 240, 0,          1'b0);
    vecs[8] = mkv(260, 300, 48'h5555, 14'h1234, 1'b1, 304, 300, 48'h12F00,  1'b0);
    vecs[9] = mkv(261, 301, 48'h6666, 14'h0001, 1'b0, 305, 305, 0,          1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    #1;

    dir_mode = 1'b1;
    for (int i = 0; i < int'(NV); i++) stimq.push_back(vecs[i].in);
    begin
      vec_t extra;
      extra = mkv(320, 340, 48'h7777, 14'h2222, 1'b1, 344, 340, 0, 1'b0);
      stimq.push_back(extra.in);
    end
    while (c < 341) step();
    check_model();
    chk("vec_updates_seen", 64'(tbl_idx), 64'(NV));
    chk("capture_holds_freq", 64'(bus.freq), 64'h6666);
    dir_mode = 1'b0;

    // Reset while the continuous command at 340 is waiting for its phase feedback
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    model_reset();
    #1;
    while (c < 60) step();

    rand_mode = 1'b1;
    while (c < 2060) step();
    chk("rand_updates_seen", 64'(n_upd > 20), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
